// File: rtl/decompress.sv
// Line decompressor: latches one packed line and replays it as NPIX reconstructed RGBA pixels.
// Optional macro DECOMP_STATS_EN adds saturating line/error counters on stat_lines_o/stat_errs_o.
module decompress #(
    parameter int NPIX  = 32,
    parameter int CH_W  = 8,
    parameter int PIX_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [1:0]            in_flag_i,
    input  logic [4*CH_W-1:0]     in_min_i,
    input  logic [11:0]           in_bits_i,
    input  logic [3:0]            in_skip_i,
    input  logic [NPIX*PIX_W-1:0] in_pix_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [PIX_W-1:0]      out_pixel_o,
    output logic [4:0]            out_idx_o,
    output logic                  out_last_o,
`ifdef DECOMP_STATS_EN
    output logic [15:0]           stat_lines_o,
    output logic [15:0]           stat_errs_o,
`endif
    output logic                  out_err_o
);
    localparam int IDX_W = $clog2(NPIX);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_DECODE = 1'b1
    } state_t;

    // Channels a,b,g,r are packed LSB-first; bits past the word end read as zero.
    function automatic logic [PIX_W-1:0] decode_word(input logic [1:0]        flag,
                                                     input logic [4*CH_W-1:0] mn,
                                                     input logic [11:0]       bits,
                                                     input logic [3:0]        skip,
                                                     input logic [PIX_W-1:0]  word);
        logic [PIX_W+CH_W-1:0] ext;
        logic [6:0]            off;
        logic [3:0]            w;
        logic [CH_W-1:0]       res;
        logic [PIX_W-1:0]      px;
        px  = '0;
        off = 7'd0;
        case (flag)
            2'b00: px = word;
            2'b01: begin
                for (int c = 0; c < 4; c++) begin
                    if (!skip[c]) begin
                        w   = {1'b0, bits[c*3 +: 3]} + 4'd1;
                        ext = {{CH_W{1'b0}}, word} >> off;
                        res = ext[CH_W-1:0] & ({CH_W{1'b1}} >> (4'd8 - w));
                        off = off + {3'b000, w};
                    end else begin
                        res = '0;
                    end
                    px[c*CH_W +: CH_W] = mn[c*CH_W +: CH_W] + res;
                end
            end
            default: px = '0;
        endcase
        return px;
    endfunction

    function automatic logic line_error(input logic [1:0]  flag,
                                        input logic [11:0] bits,
                                        input logic [3:0]  skip);
        logic [6:0] tot;
        tot = 7'd0;
        for (int c = 0; c < 4; c++) begin
            if (!skip[c]) begin
                tot = tot + {4'b0000, bits[c*3 +: 3]} + 7'd1;
            end else begin
                tot = tot;
            end
        end
        return flag[1] | ((flag == 2'b01) && (tot > 7'(PIX_W)));
    endfunction

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PIX_W-1:0]      pixel_q, pixel_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic [1:0]            flag_q;
    logic [4*CH_W-1:0]     min_q;
    logic [11:0]           bits_q;
    logic [3:0]            skip_q;
    logic [NPIX*PIX_W-1:0] pix_q;

    logic             out_valid_s, out_hs_s, last_hs_s, accept_s;
    logic [IDX_W-1:0] nidx_s;
    logic [PIX_W-1:0] dec_s;

    assign out_valid_s = (state_q == S_DECODE);
    assign out_hs_s    = out_valid_s && out_ready_i;
    assign last_hs_s   = out_hs_s && last_q;
    assign in_ready_o  = (state_q == S_IDLE) || last_hs_s;
    assign accept_s    = in_valid_i && in_ready_o;
    assign nidx_s      = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};

    // Single decoder fed either by the incoming line (beat 0) or the stored line (later beats).
    always_comb begin
        if (accept_s) begin
            dec_s = decode_word(in_flag_i, in_min_i, in_bits_i, in_skip_i, in_pix_i[PIX_W-1:0]);
        end else begin
            dec_s = decode_word(flag_q, min_q, bits_q, skip_q, pix_q[nidx_s*PIX_W +: PIX_W]);
        end
    end

    // Next-state and output-register update; a new line may replace the final beat's handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pixel_d = pixel_q;
        last_d  = last_q;
        err_d   = err_q;
        if (accept_s) begin
            state_d = S_DECODE;
            idx_d   = '0;
            pixel_d = dec_s;
            last_d  = (NPIX == 1);
            err_d   = line_error(in_flag_i, in_bits_i, in_skip_i);
        end else if (last_hs_s) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
        end else if (out_hs_s) begin
            idx_d   = nidx_s;
            pixel_d = dec_s;
            last_d  = (nidx_s == IDX_W'(NPIX-1));
        end else begin
            state_d = state_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pixel_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pixel_q <= pixel_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Line buffer; contents only matter after an accept, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            flag_q <= in_flag_i;
            min_q  <= in_min_i;
            bits_q <= in_bits_i;
            skip_q <= in_skip_i;
            pix_q  <= in_pix_i;
        end else begin
            pix_q  <= pix_q;
        end
    end

    assign out_valid_o = out_valid_s;
    assign out_pixel_o = pixel_q;
    assign out_idx_o   = 5'(idx_q);
    assign out_last_o  = last_q;
    assign out_err_o   = err_q;

`ifdef DECOMP_STATS_EN
    logic [15:0] stat_lines_q, stat_errs_q;

    // Saturating counters of completed lines and completed lines flagged in error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_lines_q <= 16'h0000;
            stat_errs_q  <= 16'h0000;
        end else if (last_hs_s) begin
            if (stat_lines_q != 16'hFFFF) begin
                stat_lines_q <= stat_lines_q + 16'd1;
            end else begin
                stat_lines_q <= stat_lines_q;
            end
            if (err_q && (stat_errs_q != 16'hFFFF)) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end else begin
                stat_errs_q <= stat_errs_q;
            end
        end else begin
            stat_lines_q <= stat_lines_q;
        end
    end

    assign stat_lines_o = stat_lines_q;
    assign stat_errs_o  = stat_errs_q;
`endif

endmodule
